// File: rtl/seq_alu_pkg.sv
// Shared definitions for seq_alu: MIPS R-type funct codes, FSM state type and
// the decode helper that separates the iterative multiply/divide operations.
package seq_alu_pkg;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2
    } state_t;

    function automatic logic is_iterative(input logic [5:0] funct);
        logic iter_s;
        case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: iter_s = 1'b1;
            default:                        iter_s = 1'b0;
        endcase
        return iter_s;
    endfunction

endpackage

// File: rtl/seq_alu_mdu.sv
// Iterative multiply/divide engine: one shift-add or restoring-divide step per
// cycle on operand magnitudes; the sign fix is applied to the final step's value.
module seq_alu_mdu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v,
                                                   input logic take_abs);
        logic [WIDTH-1:0] mag_s;
        if (take_abs && v[WIDTH-1]) begin
            mag_s = -v;
        end else begin
            mag_s = v;
        end
        return mag_s;
    endfunction

    logic             busy_r;
    logic [CW-1:0]    cnt_r;
    logic             div_r;
    logic             dz_r;
    logic             neg_q_r;
    logic             neg_r_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] m_r;
    logic [WIDTH-1:0] a_r;

    logic [WIDTH:0]     sum_s;
    logic [WIDTH:0]     trial_s;
    logic [WIDTH:0]     diff_s;
    logic [WIDTH-1:0]   acc_nxt_s;
    logic [WIDTH-1:0]   q_nxt_s;
    logic [2*WIDTH-1:0] prod_s;

    // One engine step: acc/q form the product pair or the remainder/quotient pair.
    always_comb begin
        sum_s     = {(WIDTH+1){1'b0}};
        trial_s   = {(WIDTH+1){1'b0}};
        diff_s    = {(WIDTH+1){1'b0}};
        acc_nxt_s = acc_r;
        q_nxt_s   = q_r;
        if (div_r) begin
            trial_s = {acc_r, q_r[WIDTH-1]};
            diff_s  = trial_s - {1'b0, m_r};
            if (!diff_s[WIDTH]) begin
                acc_nxt_s = diff_s[WIDTH-1:0];
                q_nxt_s   = {q_r[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt_s = trial_s[WIDTH-1:0];
                q_nxt_s   = {q_r[WIDTH-2:0], 1'b0};
            end
        end else begin
            sum_s = {1'b0, acc_r} + (q_r[0] ? {1'b0, m_r} : {(WIDTH+1){1'b0}});
            {acc_nxt_s, q_nxt_s} = {sum_s, q_r[WIDTH-1:1]};
        end
    end

    // Sign correction and divide-by-zero override on the value the last step produces.
    always_comb begin
        prod_s = neg_q_r ? -{acc_nxt_s, q_nxt_s} : {acc_nxt_s, q_nxt_s};
        if (!div_r) begin
            hi = prod_s[2*WIDTH-1:WIDTH];
            lo = prod_s[WIDTH-1:0];
        end else if (dz_r) begin
            hi = a_r;
            lo = {WIDTH{1'b1}};
        end else begin
            hi = neg_r_r ? -acc_nxt_s : acc_nxt_s;
            lo = neg_q_r ? -q_nxt_s : q_nxt_s;
        end
    end

    assign done = busy_r && (cnt_r == {CW{1'b0}});

    // Operand capture on start, then WIDTH steps counting down to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r  <= 1'b0;
            cnt_r   <= {CW{1'b0}};
            div_r   <= 1'b0;
            dz_r    <= 1'b0;
            neg_q_r <= 1'b0;
            neg_r_r <= 1'b0;
            acc_r   <= {WIDTH{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            m_r     <= {WIDTH{1'b0}};
            a_r     <= {WIDTH{1'b0}};
        end else if (start) begin
            busy_r  <= 1'b1;
            cnt_r   <= CW'(WIDTH - 1);
            div_r   <= is_div;
            dz_r    <= is_div && (b == {WIDTH{1'b0}});
            neg_q_r <= is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r <= is_signed && a[WIDTH-1];
            acc_r   <= {WIDTH{1'b0}};
            q_r     <= magnitude(a, is_signed);
            m_r     <= magnitude(b, is_signed);
            a_r     <= a;
        end else if (busy_r) begin
            acc_r <= acc_nxt_s;
            q_r   <= q_nxt_s;
            if (cnt_r == {CW{1'b0}}) begin
                busy_r <= 1'b0;
            end else begin
                cnt_r <= cnt_r - CW'(1);
            end
        end else begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Registered MIPS EX-stage ALU with HI/LO registers; single-cycle ops answer
// next cycle, multiply/divide stall the pipeline while seq_alu_mdu iterates.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       funct,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             err,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t           state_r;
    state_t           state_nxt_s;
    logic             accept_s;
    logic             iter_s;
    logic             mdu_start_s;
    logic             mdu_done_s;
    logic [WIDTH-1:0] mdu_hi_s;
    logic [WIDTH-1:0] mdu_lo_s;
    logic [WIDTH-1:0] alu_res_s;
    logic             alu_err_s;
    logic [SHW-1:0]   shamt_s;

    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             zero_r;
    logic             err_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;

    assign in_ready = (state_r == IDLE);
    assign accept_s = in_valid && in_ready;
    assign iter_s   = is_iterative(funct);
    assign shamt_s  = b[SHW-1:0];

    seq_alu_mdu #(
        .WIDTH(WIDTH)
    ) u_mdu (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (mdu_start_s),
        .is_signed (~funct[0]),
        .is_div    (funct[1]),
        .a         (a),
        .b         (b),
        .done      (mdu_done_s),
        .hi        (mdu_hi_s),
        .lo        (mdu_lo_s)
    );

    // Single-cycle operation mux; MFHI/MFLO see HI/LO as they stand at accept.
    always_comb begin
        alu_res_s = {WIDTH{1'b0}};
        alu_err_s = 1'b0;
        case (funct)
            F_ADD:  alu_res_s = a + b;
            F_SUB:  alu_res_s = a - b;
            F_AND:  alu_res_s = a & b;
            F_OR:   alu_res_s = a | b;
            F_XOR:  alu_res_s = a ^ b;
            F_NOR:  alu_res_s = ~(a | b);
            F_SLT:  alu_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            F_SLTU: alu_res_s = {{(WIDTH-1){1'b0}}, (a < b)};
            F_SLL:  alu_res_s = a << shamt_s;
            F_SRL:  alu_res_s = a >> shamt_s;
            F_SRA:  alu_res_s = $unsigned($signed(a) >>> shamt_s);
            F_MFHI: alu_res_s = hi_r;
            F_MFLO: alu_res_s = lo_r;
            F_MULT, F_MULTU, F_DIV, F_DIVU: alu_res_s = {WIDTH{1'b0}};
            default: alu_err_s = 1'b1;
        endcase
    end

    // FSM next state; the engine is started only from IDLE on an iterative accept.
    always_comb begin
        state_nxt_s = state_r;
        mdu_start_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s && iter_s) begin
                    state_nxt_s = BUSY;
                    mdu_start_s = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                if (mdu_done_s) begin
                    state_nxt_s = FIX;
                end else begin
                    state_nxt_s = BUSY;
                end
            end
            FIX:     state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output and HI/LO registers; FIX becomes visible together with the new HI/LO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            result_r    <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            err_r       <= 1'b0;
            hi_r        <= {WIDTH{1'b0}};
            lo_r        <= {WIDTH{1'b0}};
        end else begin
            out_valid_r <= 1'b0;
            if (accept_s && !iter_s) begin
                out_valid_r <= 1'b1;
                result_r    <= alu_res_s;
                zero_r      <= (alu_res_s == {WIDTH{1'b0}});
                err_r       <= alu_err_s;
            end else if (accept_s) begin
                err_r <= 1'b0;
            end else if ((state_r == BUSY) && mdu_done_s) begin
                out_valid_r <= 1'b1;
                result_r    <= mdu_lo_s;
                zero_r      <= (mdu_lo_s == {WIDTH{1'b0}});
                err_r       <= 1'b0;
                hi_r        <= mdu_hi_s;
                lo_r        <= mdu_lo_s;
            end else begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign zero      = zero_r;
    assign err       = err_r;
    assign hi        = hi_r;
    assign lo        = lo_r;

endmodule

// File: tb/tb_seq_alu.sv
// Randomised and directed bench for seq_alu at WIDTH 32, 8 and 64 against a
// plain-arithmetic model of the MIPS ALU/HI-LO semantics and latencies.
module tb_seq_alu;

    typedef struct packed {
        int          due;
        logic [63:0] res;
        logic        err;
        logic [63:0] hi;
        logic [63:0] lo;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic [5:0]  funct = 6'd0;
    logic [63:0] a = 64'd0;
    logic [63:0] b = 64'd0;
    int          sel = 0;

    logic        iv32, iv8, iv64, rdy32, rdy8, rdy64, ov32, ov8, ov64;
    logic        zr32, zr8, zr64, er32, er8, er64;
    logic [31:0] res32, hi32, lo32;
    logic [7:0]  res8, hi8, lo8;
    logic [63:0] res64, hi64, lo64;

    logic        rdy, ov, zr, er;
    logic [63:0] res, hh, ll;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   busy_end = -1;
    logic [63:0] hi_vis = 64'd0;
    logic [63:0] lo_vis = 64'd0;
    exp_t expq[$];

    logic [5:0] fl [17] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110,
                            6'b100111, 6'b101010, 6'b101011, 6'b000000, 6'b000010,
                            6'b000011, 6'b010000, 6'b010010, 6'b011000, 6'b011001,
                            6'b011010, 6'b011011};

    always #5 clk = ~clk;

    assign iv32 = in_valid && (sel == 0);
    assign iv8  = in_valid && (sel == 1);
    assign iv64 = in_valid && (sel == 2);

    seq_alu #(.WIDTH(32)) u_w32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(rdy32), .funct(funct),
        .a(a[31:0]), .b(b[31:0]), .out_valid(ov32), .result(res32), .zero(zr32),
        .err(er32), .hi(hi32), .lo(lo32));

    seq_alu #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(rdy8), .funct(funct),
        .a(a[7:0]), .b(b[7:0]), .out_valid(ov8), .result(res8), .zero(zr8),
        .err(er8), .hi(hi8), .lo(lo8));

    seq_alu #(.WIDTH(64)) u_w64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(rdy64), .funct(funct),
        .a(a), .b(b), .out_valid(ov64), .result(res64), .zero(zr64),
        .err(er64), .hi(hi64), .lo(lo64));

    assign rdy = (sel == 0) ? rdy32 : (sel == 1) ? rdy8 : rdy64;
    assign ov  = (sel == 0) ? ov32  : (sel == 1) ? ov8  : ov64;
    assign zr  = (sel == 0) ? zr32  : (sel == 1) ? zr8  : zr64;
    assign er  = (sel == 0) ? er32  : (sel == 1) ? er8  : er64;
    assign res = (sel == 0) ? {32'd0, res32} : (sel == 1) ? {56'd0, res8} : res64;
    assign hh  = (sel == 0) ? {32'd0, hi32}  : (sel == 1) ? {56'd0, hi8}  : hi64;
    assign ll  = (sel == 0) ? {32'd0, lo32}  : (sel == 1) ? {56'd0, lo8}  : lo64;

    function automatic int cur_w();
        return (sel == 0) ? 32 : (sel == 1) ? 8 : 64;
    endfunction

    function automatic logic [63:0] wmask(input int w);
        return (w == 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    endfunction

    // Reference semantics from the instruction definitions, using wide signed arithmetic.
    function automatic exp_t model(input int w, input logic [5:0] f, input logic [63:0] x,
                                   input logic [63:0] y, input logic [63:0] hi0,
                                   input logic [63:0] lo0);
        exp_t e;
        logic [63:0] m, ua, ub;
        logic signed [127:0] sa, sb, p, r;
        logic [127:0] up;
        int sh;
        m  = wmask(w);
        ua = x & m;
        ub = y & m;
        sa = $signed({64'd0, ua});
        sb = $signed({64'd0, ub});
        if (ua[w-1]) sa = sa - (128'sd1 <<< w);
        if (ub[w-1]) sb = sb - (128'sd1 <<< w);
        sh = int'(ub & 64'(w - 1));
        e = '0;
        e.hi = hi0;
        e.lo = lo0;
        case (f)
            6'b100000: e.res = (ua + ub) & m;
            6'b100010: e.res = (ua - ub) & m;
            6'b100100: e.res = ua & ub;
            6'b100101: e.res = ua | ub;
            6'b100110: e.res = ua ^ ub;
            6'b100111: e.res = ~(ua | ub) & m;
            6'b101010: e.res = (sa < sb) ? 64'd1 : 64'd0;
            6'b101011: e.res = (ua < ub) ? 64'd1 : 64'd0;
            6'b000000: e.res = (ua << sh) & m;
            6'b000010: e.res = ua >> sh;
            6'b000011: begin p = sa >>> sh; e.res = p[63:0] & m; end
            6'b010000: e.res = hi0;
            6'b010010: e.res = lo0;
            6'b011000, 6'b011001: begin
                if (f[0]) up = {64'd0, ua} * {64'd0, ub};
                else begin p = sa * sb; up = p; end
                e.lo = up[63:0] & m;
                up = up >> w;
                e.hi = up[63:0] & m;
            end
            6'b011010, 6'b011011: begin
                if (ub == 64'd0) begin
                    e.lo = m;
                    e.hi = ua;
                end else if (f[0]) begin
                    e.lo = ua / ub;
                    e.hi = ua % ub;
                end else begin
                    p = sa / sb;
                    r = sa % sb;
                    e.lo = p[63:0] & m;
                    e.hi = r[63:0] & m;
                end
            end
            default: begin e.err = 1'b1; e.res = 64'd0; end
        endcase
        if (f[5:2] == 4'b0110) e.res = e.lo;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_vec++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (w=%0d t=%0t)", nm, act, exp_v, cur_w(), $time);
        end
    endtask

    // Compare process: DUT outputs vs scoreboard each cycle, then record this cycle's accept.
    always @(negedge clk) begin
        exp_t e;
        int   w;
        logic exp_ov;
        w = cur_w();
        if (!rst_n) begin
            expq.delete();
            busy_end = -1;
            hi_vis = 64'd0;
            lo_vis = 64'd0;
            chk("rst_out_valid", {63'd0, ov}, 64'd0);
            chk("rst_in_ready", {63'd0, rdy}, 64'd1);
            chk("rst_hilo", hh | ll | res, 64'd0);
        end else begin
            if (expq.size() > 0 && expq[0].due < cyc) begin
                chk("lost_result", 64'(expq[0].due), 64'(cyc));
                void'(expq.pop_front());
            end
            exp_ov = (expq.size() > 0) && (expq[0].due == cyc);
            chk("out_valid", {63'd0, ov}, {63'd0, exp_ov});
            if (exp_ov) begin
                e = expq.pop_front();
                hi_vis = e.hi;
                lo_vis = e.lo;
                chk("result", res, e.res);
                chk("zero", {63'd0, zr}, {63'd0, (e.res == 64'd0)});
                chk("err", {63'd0, er}, {63'd0, e.err});
            end
            chk("in_ready", {63'd0, rdy}, {63'd0, (cyc > busy_end)});
            chk("hi", hh, hi_vis);
            chk("lo", ll, lo_vis);
            if (in_valid && (cyc > busy_end)) begin
                e = model(w, funct, a, b, hi_vis, lo_vis);
                if (funct[5:2] == 4'b0110) begin
                    e.due = cyc + w + 1;
                    busy_end = cyc + w + 1;
                end else begin
                    e.due = cyc + 1;
                end
                expq.push_back(e);
            end
        end
        cyc++;
    end

    task automatic issue(input logic [5:0] f, input logic [63:0] x, input logic [63:0] y);
        int   n;
        logic got;
        funct = f; a = x; b = y; in_valid = 1'b1;
        n = 0; got = 1'b0;
        while (!got) begin
            @(negedge clk);
            if (rdy) begin
                got = 1'b1;
            end else begin
                n++;
                if (n > 100) begin
                    chk("accept_timeout", 64'(n), 64'd0);
                    got = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        in_valid = 1'b0;
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_now_in_ready", {63'd0, rdy}, 64'd1);
        chk("rst_now_outputs", {62'd0, ov, zr} | res | hh | ll | {63'd0, er}, 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic logic [63:0] rnd(input int w);
        logic [63:0] m;
        m = wmask(w);
        case ($urandom_range(0, 5))
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return m;
            3:       return 64'd1 << (w - 1);
            4:       return m ^ (64'd1 << (w - 1));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic phase(input int s);
        int w;
        logic [63:0] mx, mn;
        sel = s;
        w  = cur_w();
        mx = wmask(w);
        mn = 64'd1 << (w - 1);
        do_reset();
        issue(6'b100000, mn - 64'd1, 64'd1);
        issue(6'b100010, 64'd5, 64'd5);
        issue(6'b101010, mx, 64'd1);
        issue(6'b101011, mx, 64'd1);
        issue(6'b000011, mn, 64'(w - 1));
        issue(6'b000000, 64'd1, 64'h25);
        issue(6'b011000, mx - 64'd1, 64'd3);
        issue(6'b011001, mx - 64'd1, 64'd3);
        issue(6'b011010, (-64'd7) & mx, 64'd2);
        issue(6'b011011, 64'd7, 64'd0);
        issue(6'b011010, mn, mx);
        issue(6'b111111, 64'd1, 64'd2);
        issue(6'b010000, 64'd0, 64'd0);
        issue(6'b100000, 64'd1, 64'd1);
        issue(6'b011000, 64'd3, 64'd4);
        issue(6'b010010, 64'd0, 64'd0);
        idle(2);
        for (int i = 0; i < 30; i++) begin
            int k;
            k = $urandom_range(0, 18);
            issue((k < 17) ? fl[k] : ((k == 17) ? 6'b111111 : 6'b000001), rnd(w), rnd(w));
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(3);
        if (s == 0) begin
            issue(6'b011010, 64'd100, 64'd7);
            idle(5);
            do_reset();
            issue(6'b100000, 64'd2, 64'd3);
            idle(3);
        end
        idle(w + 4);
    endtask

    initial begin
        exp_t e;
        e = model(32, 6'b100000, 64'h7FFFFFFF, 64'd1, 64'd0, 64'd0);
        chk("pin_add", e.res, 64'h80000000);
        e = model(32, 6'b100010, 64'd5, 64'd5, 64'd0, 64'd0);
        chk("pin_sub", e.res, 64'd0);
        e = model(32, 6'b101010, 64'hFFFFFFFF, 64'd1, 64'd0, 64'd0);
        chk("pin_slt", e.res, 64'd1);
        e = model(32, 6'b101011, 64'hFFFFFFFF, 64'd1, 64'd0, 64'd0);
        chk("pin_sltu", e.res, 64'd0);
        e = model(32, 6'b000011, 64'h80000000, 64'd31, 64'd0, 64'd0);
        chk("pin_sra", e.res, 64'hFFFFFFFF);
        e = model(32, 6'b000000, 64'd1, 64'h25, 64'd0, 64'd0);
        chk("pin_sll", e.res, 64'h20);
        e = model(32, 6'b011000, 64'hFFFFFFFE, 64'd3, 64'd0, 64'd0);
        chk("pin_mult", {e.hi[31:0], e.lo[31:0]}, 64'hFFFFFFFF_FFFFFFFA);
        e = model(32, 6'b011001, 64'hFFFFFFFE, 64'd3, 64'd0, 64'd0);
        chk("pin_multu", {e.hi[31:0], e.lo[31:0]}, 64'h00000002_FFFFFFFA);
        e = model(32, 6'b011010, 64'hFFFFFFF9, 64'd2, 64'd0, 64'd0);
        chk("pin_div", {e.hi[31:0], e.lo[31:0]}, 64'hFFFFFFFF_FFFFFFFD);
        e = model(32, 6'b011011, 64'd7, 64'd0, 64'd0, 64'd0);
        chk("pin_divu0", {e.hi[31:0], e.lo[31:0]}, 64'h00000007_FFFFFFFF);
        e = model(32, 6'b011010, 64'h80000000, 64'hFFFFFFFF, 64'd0, 64'd0);
        chk("pin_divmin", {e.hi[31:0], e.lo[31:0]}, 64'h00000000_80000000);
        e = model(8, 6'b011000, 64'hFE, 64'd3, 64'd0, 64'd0);
        chk("pin_mult8", {e.hi[31:0], e.lo[31:0]}, 64'h000000FF_000000FA);
        e = model(64, 6'b011010, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'd0, 64'd0);
        chk("pin_div64", e.lo, 64'hFFFFFFFFFFFFFFFD);
        e = model(32, 6'b111111, 64'd1, 64'd2, 64'd9, 64'd8);
        chk("pin_illegal", {e.res[31:0], 31'd0, e.err}, 64'h00000000_00000001);

        @(posedge clk);
        #1;
        phase(0);
        phase(1);
        phase(2);
        chk("queue_drained", 64'(expq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

endmodule
